booth_mul_scheduler: RTL and testbench
======================================

BOOTH_MUL_SCHEDULER -- requirements
Module: booth_mul_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one Booth multiplier core.
REQ-002 Parameter W, default 8, operand width; product width is 2*W.
REQ-003 Parameter TIMEOUT, default 31, maximum WAIT-state cycles before a job is aborted.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst_b  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N_REQ  per-requester job request; held high until the matching gnt bit pulses.
REQ-007 req_x  input  N_REQ*W  packed multiplicands, slice i belongs to requester i.
REQ-008 req_y  input  N_REQ*W  packed multipliers, slice i belongs to requester i.
REQ-009 gnt  output  N_REQ  one-hot, one-cycle pulse marking acceptance of a requester's job.
REQ-010 mul_bgn  output  1  one-cycle start pulse to the multiplier core.
REQ-011 mul_x, mul_y  output  W each  operands presented to the core, stable from mul_bgn until response.
REQ-012 mul_done  input  1  core completion (core stop), sampled only in WAIT.
REQ-013 mul_p  input  2*W  core signed product, valid while mul_done is high.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_id  output  log2(N_REQ)  index of the requester that owns the response.
REQ-017 rsp_p  output  2*W  product; rsp_err  output  1  job aborted by timeout.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, START, WAIT, RESP; one job in flight at a time.
REQ-020 IDLE: on an edge with req nonzero, winner = first set bit of req searched from rr pointer upward, wrapping modulo N_REQ.
REQ-021 On that edge: latch winner's req_x/req_y into mul_x/mul_y, latch id, register gnt[id]=1 for the next cycle only, set pointer to (id+1) mod N_REQ, go START.
REQ-022 req bits that drop before acceptance are ignored; req==0 keeps IDLE with pointer unchanged.
REQ-023 START: mul_bgn=1 for exactly this one cycle, timer cleared, next state WAIT.
REQ-024 WAIT: timer increments per cycle; on mul_done=1, capture mul_p into rsp_p, rsp_err=0, go RESP.
REQ-025 WAIT: on timer==TIMEOUT with mul_done=0, rsp_p=0, rsp_err=1, go RESP; mul_done and timeout on the same cycle -> mul_done wins.
REQ-026 RESP: rsp_valid=1; rsp_id, rsp_p, rsp_err held stable until an edge with rsp_ready=1, then IDLE with rsp_valid=0 next cycle.
REQ-027 mul_done outside WAIT has no effect.
REQ-028 Latency: gnt one cycle after the accepting edge; mul_bgn in the same cycle as gnt; rsp_valid the cycle after mul_done.
REQ-029 Minimum gap between back-to-back grants: RESP handshake cycle plus one IDLE cycle.

Reset
REQ-030 rst_b low: state IDLE, pointer 0, timer 0, gnt=0, mul_bgn=0, mul_x=mul_y=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0, busy=0.
REQ-031 Reset mid-job discards the job silently; no response is produced; the core is reset by the shared rst_b.

Structure
REQ-032 Shared package booth_pkg holds the state enumeration, default W, and default TIMEOUT.
REQ-033 One sub-module booth_rr_pick: combinational round-robin selector (req, pointer -> one-hot winner, index, any).
REQ-034 All outputs registered; no combinational path from req or rsp_ready to any output.

Verification
REQ-035 Single job: req=0001, x=3, y=-5, core done after 10 cycles -> gnt=0001 once, rsp_id=0, rsp_p=16'hFFF1, rsp_err=0.
REQ-036 Fairness: req=1111 held for 4 jobs from reset -> grant order 0,1,2,3, then 0 again.
REQ-037 Timeout: mul_done never asserted -> rsp_valid exactly TIMEOUT+1 cycles after mul_bgn, rsp_err=1, rsp_p=0.
REQ-038 Backpressure: rsp_ready low for 5 cycles -> rsp_* stable, busy=1, no new gnt despite pending req=0100.
REQ-039 Reset in WAIT: rst_b low for 1 cycle -> all outputs at reset values, no rsp_valid, next req=0010 granted to id 1.
REQ-040 Done/timeout collision: mul_done=1 on timer==TIMEOUT, mul_p=16'h0024 -> rsp_err=0, rsp_p=16'h0024.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared state encoding and default sizing for the Booth multiplier scheduler.
package booth_pkg;

    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } booth_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/booth_rr_pick.sv
// Combinational round-robin selector: first set request at or above the pointer, wrapping.
module booth_rr_pick
    import booth_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    always_comb begin : pick
        int unsigned j;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        j        = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = (32'(i_ptr) + k) % N_REQ;
            if (!o_any && i_req[j]) begin
                o_onehot[j] = 1'b1;
                o_idx       = IW'(j);
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Arbitrates N_REQ requesters onto one Booth multiplier core, one job in flight,
// with a WAIT-state timeout and a registered valid/ready response port.
module booth_mul_scheduler
    import booth_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       req_x,
    input  logic [N_REQ*W-1:0]       req_y,
    output logic [N_REQ-1:0]         gnt,
    output logic                     mul_bgn,
    output logic [W-1:0]             mul_x,
    output logic [W-1:0]             mul_y,
    input  logic                     mul_done,
    input  logic [2*W-1:0]           mul_p,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [idx_w(N_REQ)-1:0]  rsp_id,
    output logic [2*W-1:0]           rsp_p,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int IW = idx_w(N_REQ);
    localparam int TW = idx_w(TIMEOUT + 1);

    booth_state_e       r_state, w_state_nxt;
    logic [IW-1:0]      r_ptr, r_id, w_idx;
    logic [TW-1:0]      r_timer;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_any, w_timeout;
    logic [W-1:0]       w_sel_x, w_sel_y;

    booth_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_sel_x   = req_x[32'(w_idx)*W +: W];
    assign w_sel_y   = req_y[32'(w_idx)*W +: W];
    assign w_timeout = (r_timer == TW'(TIMEOUT));
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (mul_done || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Timer is zeroed on acceptance and counts through START, so its value in
    // WAIT equals cycles elapsed since mul_bgn; timeout lands TIMEOUT+1 after it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_timer   <= '0;
            gnt       <= '0;
            mul_bgn   <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            gnt     <= '0;
            mul_bgn <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        mul_x   <= w_sel_x;
                        mul_y   <= w_sel_y;
                        r_id    <= w_idx;
                        gnt     <= w_onehot;
                        mul_bgn <= 1'b1;
                        r_timer <= '0;
                        r_ptr   <= (32'(w_idx) == N_REQ - 1) ? '0 : w_idx + IW'(1);
                    end
                end
                ST_START: r_timer <= r_timer + TW'(1);
                ST_WAIT: begin
                    if (mul_done) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_p     <= mul_p;
                        rsp_err   <= 1'b0;
                    end else if (w_timeout) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_p     <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Scoreboard bench for booth_mul_scheduler with a behavioural multiplier core model.
module tb_booth_mul_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 31;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_x = '0, req_y = '0;
    logic [N-1:0]     gnt;
    logic             mul_bgn;
    logic [W-1:0]     mul_x, mul_y;
    logic             mul_done = 1'b0;
    logic [2*W-1:0]   mul_p = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [1:0]       rsp_id;
    logic [2*W-1:0]   rsp_p;
    logic             rsp_err, busy;

    booth_mul_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .mul_bgn(mul_bgn), .mul_x(mul_x), .mul_y(mul_y),
        .mul_done(mul_done), .mul_p(mul_p), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] p;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0, n_errors = 0;
    int          m_ptr = 0;
    logic [7:0]  vx[N], vy[N];
    int          core_lat = -1, core_cnt = 0;
    bit          core_act = 0;
    logic [7:0]  cx, cy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb16;
        sa   = $signed(a);
        sb16 = $signed(b);
        return sa * sb16;
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int ptr);
        for (int k = 0; k < N; k++)
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_ops();
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = vx[i];
            req_y[i*W +: W] = vy[i];
        end
    endtask

    // Core model: done asserted core_lat cycles after the mul_bgn cycle (-1 = never).
    initial forever begin
        @(negedge clk);
        if (!rst_b) begin
            core_act = 0; mul_done = 1'b0; mul_p = '0;
        end else if (mul_bgn) begin
            cx = mul_x; cy = mul_y; core_cnt = 0; core_act = 1; mul_done = 1'b0;
            if (core_lat == 0) begin
                mul_done = 1'b1; mul_p = prod(cx, cy); core_act = 0;
            end
        end else if (core_act) begin
            core_cnt++;
            if (core_cnt == core_lat) begin
                mul_done = 1'b1; mul_p = prod(cx, cy); core_act = 0;
            end else begin
                mul_done = 1'b0;
            end
        end else begin
            mul_done = 1'b0;
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_gnt"},  {28'd0, gnt}, 32'd0);
        check({tag, "_bgn"},  {31'd0, mul_bgn}, 32'd0);
        check({tag, "_mxy"},  {16'd0, mul_x, mul_y}, 32'd0);
        check({tag, "_rsp"},  {13'd0, rsp_valid, rsp_id, rsp_p, rsp_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst_b = 1'b0; req = '0; rsp_ready = 1'b0; core_lat = -1;
        tick(); tick();
        rst_b = 1'b1; m_ptr = 0; sb.delete();
    endtask

    task automatic start_job(input logic [N-1:0] mask, input int lat, input bit hold);
        exp_t e;
        bit   got;
        req = req | mask;
        core_lat = lat;
        e.id  = pick(req, m_ptr);
        e.err = !(lat >= 1 && lat <= TO);
        e.p   = e.err ? 16'h0 : prod(vx[e.id], vy[e.id]);
        e.lat = e.err ? TO + 1 : lat + 1;
        sb.push_back(e);
        m_ptr = (e.id + 1) % N;
        got = 0;
        for (int c = 0; c < 4 && !got; c++) begin
            tick();
            if (gnt != '0) got = 1;
        end
        check("gnt", {28'd0, gnt}, 32'd1 << e.id);
        check("bgn_with_gnt", {31'd0, mul_bgn}, 32'd1);
        check("busy_start", {31'd0, busy}, 32'd1);
        check("mul_x", {24'd0, mul_x}, {24'd0, vx[e.id]});
        check("mul_y", {24'd0, mul_y}, {24'd0, vy[e.id]});
        if (!hold) req[e.id] = 1'b0;
        tick();
        check("gnt_pulse", {28'd0, gnt}, 32'd0);
        check("bgn_pulse", {31'd0, mul_bgn}, 32'd0);
    endtask

    task automatic finish_job(input int stall, input logic [N-1:0] pend);
        exp_t e;
        int   cyc;
        cyc = 1;
        while (!rsp_valid && cyc < TO + 10) begin
            tick();
            cyc++;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("rsp_latency", cyc, e.lat);
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_id", {30'd0, rsp_id}, e.id);
        check("rsp_p", {16'd0, rsp_p}, {16'd0, e.p});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        req = req | pend;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("bp_hold", {13'd0, rsp_valid, rsp_id, rsp_p, rsp_err},
                  {13'd0, 1'b1, 2'(e.id), e.p, e.err});
            check("bp_busy_nognt", {27'd0, busy, gnt}, {27'd0, 1'b1, 4'd0});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_hs", {26'd0, rsp_valid, busy, gnt}, 32'd0);
    endtask

    initial begin
        vx[0] = 8'd3;   vy[0] = 8'hFB;
        vx[1] = 8'hF9;  vy[1] = 8'd9;
        vx[2] = 8'd100; vy[2] = 8'hFE;
        vx[3] = 8'h80;  vy[3] = 8'd127;
        load_ops();
        tick();
        check_reset_outs("reset");
        rst_b = 1'b1;
        tick();

        // Single job, done 10 cycles after start
        start_job(4'b0001, 10, 0);
        finish_job(0, 4'b0000);
        check("single_p_const", {16'd0, rsp_p}, 32'h0000FFF1);

        // Fairness with all requests held
        do_reset();
        req = 4'b1111;
        start_job(4'b1111, 2, 1); finish_job(0, 4'b0000);
        start_job(4'b1111, 3, 1); finish_job(0, 4'b0000);
        start_job(4'b1111, 4, 1); finish_job(0, 4'b0000);
        start_job(4'b1111, 5, 1); finish_job(0, 4'b0000);
        start_job(4'b1111, 1, 1);
        req = '0;
        finish_job(0, 4'b0000);

        // mul_done in START is ignored -> timeout
        start_job(4'b0001, 0, 0); finish_job(0, 4'b0000);

        // Core never responds
        start_job(4'b0010, -1, 0); finish_job(0, 4'b0000);

        // Backpressure with a pending request
        start_job(4'b0001, 3, 0); finish_job(5, 4'b0100);
        start_job(4'b0100, 4, 0); finish_job(0, 4'b0000);

        // Done on the timeout cycle
        vx[2] = 8'd6; vy[2] = 8'd6;
        load_ops();
        start_job(4'b0100, TO, 0); finish_job(0, 4'b0000);

        // Reset while in WAIT discards the job
        start_job(4'b0001, -1, 0);
        tick(); tick(); tick();
        rst_b = 1'b0;
        void'(sb.pop_back());
        #1;
        check_reset_outs("rst_wait");
        tick();
        rst_b = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_rsp_after_rst", {30'd0, rsp_valid, busy}, 32'd0);
        end
        start_job(4'b0010, 6, 0); finish_job(0, 4'b0000);

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
